// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch/jump/call/return with a return-address
// stack and sticky stack-error flags.
module pc_sequencer #(
  parameter int PC_W      = 5,
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0,
  localparam int DW       = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              control,
  input  logic              isBranch,
  input  logic              isJump,
  input  logic              isCall,
  input  logic              isRet,
  input  logic              relMode,
  input  logic [2:0]        cond,
  input  logic [DATA_W-1:0] regA,
  input  logic [DATA_W-1:0] regB,
  input  logic [IMM_W-1:0]  imm,
  output logic [PC_W-1:0]   PC,
  output logic [DW-1:0]     depth,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int MW = (PC_W > IMM_W) ? PC_W : IMM_W;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];

  logic [PC_W-1:0]   seq, target, top;
  logic signed [MW-1:0] imm_sx;
  logic [MW-1:0]     imm_zx;
  logic              full, empty, taken;
  logic              eq, lt_s, lt_u;

  assign seq    = pc_q + PC_W'(1);
  assign imm_sx = MW'($signed(imm));
  assign imm_zx = MW'(imm);
  assign target = relMode ? seq + imm_sx[PC_W-1:0]
                          : imm_zx[PC_W-1:0];
  assign top    = ras_q[IW'(depth_q - DW'(1))];
  assign full   = (depth_q == DW'(RAS_DEPTH));
  assign empty  = (depth_q == '0);

  assign eq   = (regA == regB);
  assign lt_s = ($signed(regA) < $signed(regB));
  assign lt_u = (regA < regB);

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'd0:    taken = eq;
      3'd1:    taken = !eq;
      3'd2:    taken = lt_s;
      3'd3:    taken = !lt_s;
      3'd4:    taken = lt_u;
      3'd5:    taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

  // Priority: ret > call > jump > branch > sequential
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (control) begin
      if (isRet) begin
        if (!empty) begin
          pc_d    = top;
          depth_d = depth_q - DW'(1);
        end else begin
          unf_d = 1'b1;
          pc_d  = seq;
        end
      end else if (isCall) begin
        if (!full) begin
          push    = 1'b1;
          pc_d    = target;
          depth_d = depth_q + DW'(1);
        end else begin
          ovf_d = 1'b1;
          pc_d  = seq;
        end
      end else if (isJump) begin
        pc_d = target;
      end else if (isBranch) begin
        pc_d = taken ? target : seq;
      end else begin
        pc_d = seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= PC_W'(RESET_PC);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; only entries below depth are read
  always_ff @(posedge clk) begin
    if (push) ras_q[IW'(depth_q)] <= seq;
  end

  assign PC          = pc_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
